// File: rtl/main_controller.sv
// main_controller: multi-cycle RISC-V control FSM (fetch/decode/execute/memory/writeback)
// Ports:
//   clk, rst (async, active-low)
//   opcode, func3, func7 : instruction fields from IR
//   zer, neg             : ALU flags for branch resolution
//   pcen, adrsrc, memwrite, irwrite, regwrite, alusrca, alusrcb,
//   aluop, resultsrc, immsrc : datapath controls
//   halted               : illegal-instruction halt flag
// Build option: define ILLEGAL_HALT_EN to make an illegal instruction halt the core
// until reset; otherwise it runs as a 3-cycle NOP and halted stays 0.
module main_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       zer,
    input  logic       neg,
    output logic       pcen,
    output logic       adrsrc,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] aluop,
    output logic [1:0] resultsrc,
    output logic [2:0] immsrc,
    output logic       halted
);
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXER, EXEI,
        ALUWB, BRANCH, JAL, JALR1, JALR2, LUI, ILLEGAL
    } state_t;

    state_t     state, next;
    logic [2:0] f3_op;
    logic       f3_ok, r_ok, b_ok, take;

    // Function-field legality is resolved in DECODE so an unsupported
    // encoding never reaches an execute state.
    always_comb begin
        f3_op = func3 == 3'b111 ? ALU_AND :
                func3 == 3'b110 ? ALU_OR :
                func3 == 3'b100 ? ALU_XOR :
                func3 == 3'b010 ? ALU_SLT :
                func3 == 3'b011 ? ALU_SLTU : ALU_ADD;
        f3_ok = func3 != 3'b001 && func3 != 3'b101;
        r_ok  = f3_ok && (func7 == 7'b0000000 || (func7 == 7'b0100000 && func3 == 3'b000));
        b_ok  = func3 == 3'b000 || func3 == 3'b001 || func3 == 3'b100 || func3 == 3'b101;
        take  = (func3 == 3'b000 && zer) || (func3 == 3'b001 && !zer) ||
                (func3 == 3'b100 && neg) || (func3 == 3'b101 && !neg);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FETCH;
        else      state <= next;
    end

    always_comb begin
        next      = FETCH;
        pcen      = 1'b0;
        adrsrc    = 1'b0;
        memwrite  = 1'b0;
        irwrite   = 1'b0;
        regwrite  = 1'b0;
        alusrca   = 2'd0;
        alusrcb   = 2'd0;
        aluop     = ALU_ADD;
        resultsrc = 2'd0;
        immsrc    = IMM_I;
        halted    = 1'b0;
        // Outputs are forced to 0 for as long as reset is held.
        if (rst) begin
            case (state)
                FETCH: begin
                    irwrite   = 1'b1;
                    alusrcb   = 2'd2;
                    resultsrc = 2'd1;
                    pcen      = 1'b1;
                    next      = DECODE;
                end
                DECODE: begin
                    alusrca = 2'd1;
                    alusrcb = 2'd1;
                    immsrc  = opcode == OP_JAL ? IMM_J : IMM_B;
                    case (opcode)
                        OP_LW, OP_SW: next = MEMADR;
                        OP_R:         next = r_ok ? EXER : ILLEGAL;
                        OP_I:         next = f3_ok ? EXEI : ILLEGAL;
                        OP_BR:        next = b_ok ? BRANCH : ILLEGAL;
                        OP_JAL:       next = JAL;
                        OP_JALR:      next = JALR1;
                        OP_LUI:       next = LUI;
                        default:      next = ILLEGAL;
                    endcase
                end
                MEMADR: begin
                    alusrca = 2'd2;
                    alusrcb = 2'd1;
                    immsrc  = opcode == OP_LW ? IMM_I : IMM_S;
                    next    = opcode == OP_LW ? MEMREAD : MEMWRITE;
                end
                MEMREAD: begin
                    adrsrc = 1'b1;
                    next   = MEMWB;
                end
                MEMWB: begin
                    resultsrc = 2'd2;
                    regwrite  = 1'b1;
                end
                MEMWRITE: begin
                    adrsrc   = 1'b1;
                    memwrite = 1'b1;
                end
                EXER: begin
                    alusrca = 2'd2;
                    aluop   = func7[5] ? ALU_SUB : f3_op;
                    next    = ALUWB;
                end
                EXEI: begin
                    alusrca = 2'd2;
                    alusrcb = 2'd1;
                    aluop   = f3_op;
                    next    = ALUWB;
                end
                ALUWB: regwrite = 1'b1;
                BRANCH: begin
                    alusrca = 2'd2;
                    aluop   = ALU_SUB;
                    pcen    = take;
                end
                JAL, JALR2: begin
                    pcen    = 1'b1;
                    alusrca = 2'd1;
                    alusrcb = 2'd2;
                    next    = ALUWB;
                end
                JALR1: begin
                    alusrca = 2'd2;
                    alusrcb = 2'd1;
                    next    = JALR2;
                end
                LUI: begin
                    immsrc    = IMM_U;
                    resultsrc = 2'd3;
                    regwrite  = 1'b1;
                end
                ILLEGAL: begin
`ifdef ILLEGAL_HALT_EN
                    halted = 1'b1;
                    next   = ILLEGAL;
`else
                    next   = FETCH;
`endif
                end
                default: next = FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_main_controller.sv
// tb_main_controller: directed, table-driven bench for main_controller
module tb_main_controller;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic [2:0] func3 = 3'd0;
    logic [6:0] func7 = 7'd0;
    logic       zer = 1'b0;
    logic       neg = 1'b0;
    logic       pcen, adrsrc, memwrite, irwrite, regwrite, halted;
    logic [1:0] alusrca, alusrcb, resultsrc;
    logic [2:0] aluop, immsrc;
    logic [17:0] got;
    int errors = 0;
    int checks = 0;

    main_controller dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7),
        .zer(zer), .neg(neg), .pcen(pcen), .adrsrc(adrsrc), .memwrite(memwrite),
        .irwrite(irwrite), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .aluop(aluop), .resultsrc(resultsrc), .immsrc(immsrc), .halted(halted)
    );

    always #5 clk = ~clk;

    assign got = {pcen, adrsrc, memwrite, irwrite, regwrite, alusrca, alusrcb,
                  aluop, resultsrc, immsrc, halted};

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RR = 7'b0110011,
                           II = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111,
                           JR = 7'b1100111, LU = 7'b0110111, BAD = 7'b1111111;

    // {pcen,adrsrc,memwrite,irwrite,regwrite,alusrca,alusrcb,aluop,resultsrc,immsrc,halted}
    localparam logic [17:0] W_FETCH = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd2, 3'd0, 2'd1, 3'd0, 1'b0};
    localparam logic [17:0] W_DEC_B = {5'b0, 2'd1, 2'd1, 3'd0, 2'd0, 3'd2, 1'b0};
    localparam logic [17:0] W_DEC_J = {5'b0, 2'd1, 2'd1, 3'd0, 2'd0, 3'd4, 1'b0};
    localparam logic [17:0] W_ADR_I = {5'b0, 2'd2, 2'd1, 3'd0, 2'd0, 3'd0, 1'b0};
    localparam logic [17:0] W_ADR_S = {5'b0, 2'd2, 2'd1, 3'd0, 2'd0, 3'd1, 1'b0};
    localparam logic [17:0] W_MRD   = {1'b0, 1'b1, 3'b0, 2'd0, 2'd0, 3'd0, 2'd0, 3'd0, 1'b0};
    localparam logic [17:0] W_MWB   = {4'b0, 1'b1, 2'd0, 2'd0, 3'd0, 2'd2, 3'd0, 1'b0};
    localparam logic [17:0] W_MWR   = {1'b0, 1'b1, 1'b1, 2'b0, 2'd0, 2'd0, 3'd0, 2'd0, 3'd0, 1'b0};
    localparam logic [17:0] W_ALUWB = {4'b0, 1'b1, 2'd0, 2'd0, 3'd0, 2'd0, 3'd0, 1'b0};
    localparam logic [17:0] W_JUMP  = {1'b1, 4'b0, 2'd1, 2'd2, 3'd0, 2'd0, 3'd0, 1'b0};
    localparam logic [17:0] W_LUI   = {4'b0, 1'b1, 2'd0, 2'd0, 3'd0, 2'd3, 3'd3, 1'b0};
    localparam logic [17:0] W_ZERO  = 18'd0;
    localparam logic [17:0] W_HALT  = 18'd1;

    function automatic logic [17:0] exr(input logic [2:0] op);
        return {5'b0, 2'd2, 2'd0, op, 2'd0, 3'd0, 1'b0};
    endfunction

    function automatic logic [17:0] exi(input logic [2:0] op);
        return {5'b0, 2'd2, 2'd1, op, 2'd0, 3'd0, 1'b0};
    endfunction

    function automatic logic [17:0] brw(input logic t);
        return {t, 4'b0, 2'd2, 2'd0, 3'd1, 2'd0, 3'd0, 1'b0};
    endfunction

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        z;
        logic        n;
        logic [17:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                       input logic z, input logic n, input logic [17:0] e);
        vec_t v;
        v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.n = n; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [17:0] e);
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s: got %05h expected %05h", nm, got, e);
        end
    endtask

    // Called at a falling edge: drive, settle, compare, advance to next falling edge.
    task automatic step(input string nm, input logic [6:0] o, input logic [2:0] f3,
                        input logic [6:0] f7, input logic z, input logic n, input logic [17:0] e);
        opcode = o; func3 = f3; func7 = f7; zer = z; neg = n;
        #1;
        chk(nm, e);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("reset_zero", W_ZERO);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_illegal(input string nm, input logic [6:0] o, input logic [2:0] f3,
                               input logic [6:0] f7);
        step({nm, "_fetch"}, o, f3, f7, 1'b0, 1'b0, W_FETCH);
        step({nm, "_decode"}, o, f3, f7, 1'b0, 1'b0, o == JL ? W_DEC_J : W_DEC_B);
`ifdef ILLEGAL_HALT_EN
        for (int i = 0; i < 20; i++) step({nm, "_halted"}, o, f3, f7, 1'b1, 1'b1, W_HALT);
`else
        step({nm, "_nop"}, o, f3, f7, 1'b1, 1'b1, W_ZERO);
        step({nm, "_refetch"}, o, f3, f7, 1'b0, 1'b0, W_FETCH);
`endif
        do_reset();
    endtask

    initial begin
        // lw: 5 cycles
        add(LW, 3'b010, 7'd0, 0, 0, W_FETCH);
        add(LW, 3'b010, 7'd0, 0, 0, W_DEC_B);
        add(LW, 3'b010, 7'd0, 0, 0, W_ADR_I);
        add(LW, 3'b010, 7'd0, 0, 0, W_MRD);
        add(LW, 3'b010, 7'd0, 0, 0, W_MWB);
        // sw: 4 cycles
        add(SW, 3'b010, 7'd0, 1, 1, W_FETCH);
        add(SW, 3'b010, 7'd0, 1, 1, W_DEC_B);
        add(SW, 3'b010, 7'd0, 1, 1, W_ADR_S);
        add(SW, 3'b010, 7'd0, 1, 1, W_MWR);
        // sub
        add(RR, 3'b000, 7'b0100000, 0, 0, W_FETCH);
        add(RR, 3'b000, 7'b0100000, 0, 0, W_DEC_B);
        add(RR, 3'b000, 7'b0100000, 0, 0, exr(3'b001));
        add(RR, 3'b000, 7'b0100000, 0, 0, W_ALUWB);
        // add, and, sltu
        add(RR, 3'b000, 7'd0, 0, 1, W_FETCH);
        add(RR, 3'b000, 7'd0, 0, 1, W_DEC_B);
        add(RR, 3'b000, 7'd0, 0, 1, exr(3'b000));
        add(RR, 3'b000, 7'd0, 0, 1, W_ALUWB);
        add(RR, 3'b111, 7'd0, 1, 0, W_FETCH);
        add(RR, 3'b111, 7'd0, 1, 0, W_DEC_B);
        add(RR, 3'b111, 7'd0, 1, 0, exr(3'b010));
        add(RR, 3'b111, 7'd0, 1, 0, W_ALUWB);
        add(RR, 3'b011, 7'd0, 0, 0, W_FETCH);
        add(RR, 3'b011, 7'd0, 0, 0, W_DEC_B);
        add(RR, 3'b011, 7'd0, 0, 0, exr(3'b110));
        add(RR, 3'b011, 7'd0, 0, 0, W_ALUWB);
        // xori, ori (func7 ignored for I-type)
        add(II, 3'b100, 7'd0, 0, 0, W_FETCH);
        add(II, 3'b100, 7'd0, 0, 0, W_DEC_B);
        add(II, 3'b100, 7'd0, 0, 0, exi(3'b100));
        add(II, 3'b100, 7'd0, 0, 0, W_ALUWB);
        add(II, 3'b110, 7'b0100000, 0, 0, W_FETCH);
        add(II, 3'b110, 7'b0100000, 0, 0, W_DEC_B);
        add(II, 3'b110, 7'b0100000, 0, 0, exi(3'b011));
        add(II, 3'b110, 7'b0100000, 0, 0, W_ALUWB);
        // branches: beq z=1 taken, bne z=1 not, blt n=1 taken, bge n=1 not, beq z=0 not
        add(BR, 3'b000, 7'd0, 1, 0, W_FETCH);
        add(BR, 3'b000, 7'd0, 1, 0, W_DEC_B);
        add(BR, 3'b000, 7'd0, 1, 0, brw(1'b1));
        add(BR, 3'b001, 7'd0, 1, 0, W_FETCH);
        add(BR, 3'b001, 7'd0, 1, 0, W_DEC_B);
        add(BR, 3'b001, 7'd0, 1, 0, brw(1'b0));
        add(BR, 3'b100, 7'd0, 0, 1, W_FETCH);
        add(BR, 3'b100, 7'd0, 0, 1, W_DEC_B);
        add(BR, 3'b100, 7'd0, 0, 1, brw(1'b1));
        add(BR, 3'b101, 7'd0, 0, 1, W_FETCH);
        add(BR, 3'b101, 7'd0, 0, 1, W_DEC_B);
        add(BR, 3'b101, 7'd0, 0, 1, brw(1'b0));
        add(BR, 3'b000, 7'd0, 0, 1, W_FETCH);
        add(BR, 3'b000, 7'd0, 0, 1, W_DEC_B);
        add(BR, 3'b000, 7'd0, 0, 1, brw(1'b0));
        // jal
        add(JL, 3'b000, 7'd0, 1, 1, W_FETCH);
        add(JL, 3'b000, 7'd0, 1, 1, W_DEC_J);
        add(JL, 3'b000, 7'd0, 1, 1, W_JUMP);
        add(JL, 3'b000, 7'd0, 1, 1, W_ALUWB);
        // jalr
        add(JR, 3'b000, 7'd0, 0, 0, W_FETCH);
        add(JR, 3'b000, 7'd0, 0, 0, W_DEC_B);
        add(JR, 3'b000, 7'd0, 0, 0, W_ADR_I);
        add(JR, 3'b000, 7'd0, 0, 0, W_JUMP);
        add(JR, 3'b000, 7'd0, 0, 0, W_ALUWB);
        // lui, then a fresh fetch
        add(LU, 3'b000, 7'd0, 0, 0, W_FETCH);
        add(LU, 3'b000, 7'd0, 0, 0, W_DEC_B);
        add(LU, 3'b000, 7'd0, 0, 0, W_LUI);
        add(LW, 3'b010, 7'd0, 0, 0, W_FETCH);

        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            {opcode, func3, func7, zer, neg} = 19'($urandom);
            #1;
            chk("reset_hold", W_ZERO);
            @(negedge clk);
        end
        rst = 1'b1;
        for (int i = 0; i < tbl.size(); i++)
            step($sformatf("vec[%0d]", i), tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].z, tbl[i].n, tbl[i].exp);

        // reset mid-instruction: lw aborted in MEMREAD, write suppressed
        do_reset();
        step("abort_fetch", LW, 3'b010, 7'd0, 0, 0, W_FETCH);
        step("abort_decode", LW, 3'b010, 7'd0, 0, 0, W_DEC_B);
        step("abort_memadr", LW, 3'b010, 7'd0, 0, 0, W_ADR_I);
        rst = 1'b0;
        #1;
        chk("abort_async", W_ZERO);
        @(negedge clk);
        #1;
        chk("abort_no_write", W_ZERO);
        @(negedge clk);
        rst = 1'b1;
        step("abort_restart", LW, 3'b010, 7'd0, 0, 0, W_FETCH);
        do_reset();

        run_illegal("ill_opcode", BAD, 3'b000, 7'd0);
        run_illegal("ill_r_func7", RR, 3'b000, 7'b0000001);
        run_illegal("ill_i_shift", II, 3'b001, 7'd0);
        run_illegal("ill_bltu", BR, 3'b110, 7'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
